// File: rtl/seq_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// seq_frame_pkg
// Shared types and constants for the seq_frame_tx serial frame transmitter.
//   state_t      : 2-bit FSM state; the encoding is visible on current_state
//   SYNC_W       : number of sync header bits
//   SYNC_PATTERN : header bits, sent MSB first
//   max3()       : constant helper used to size the bit counter
// -----------------------------------------------------------------------------
package seq_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SYNC = 2'b01,
      ST_DATA = 2'b11,
      ST_GAP  = 2'b10
   } state_t;

   localparam int                SYNC_W       = 4;
   localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// -----------------------------------------------------------------------------
// seq_frame_tx_if
// Word-load handshake between a data source and seq_frame_tx.
//   load_valid : source -> tx, load_data is valid
//   load_ready : tx -> source, transmitter can take a word
//   load_data  : source -> tx, payload word (DATA_W bits)
// Modports: master = word source, slave = transmitter.
// -----------------------------------------------------------------------------
interface seq_frame_tx_if #(
   parameter int DATA_W = 8
) ();

   logic              load_valid;
   logic              load_ready;
   logic [DATA_W-1:0] load_data;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/seq_tx_shifter.sv
// -----------------------------------------------------------------------------
// seq_tx_shifter
// Parallel-load, shift-left, zero-fill register. Load has priority over shift.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-high; clears the register
//   i_load  : capture i_data
//   i_shift : shift left one place, zero into the LSB
//   i_data  : parallel load word
//   o_msb   : current MSB of the register
// -----------------------------------------------------------------------------
module seq_tx_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_msb
);

   logic [DATA_W-1:0] r_shift;

   // shift register: load wins over shift, otherwise hold
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_shift <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
      end else if (i_shift) begin
         r_shift <= r_shift << 1;
      end else begin
         r_shift <= r_shift;
      end
   end

   assign o_msb = r_shift[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// -----------------------------------------------------------------------------
// seq_frame_tx
// Serial frame transmitter feeding a downstream 1011 sync detector. A word
// taken over the load handshake is sent one bit per clock, MSB first, as
//   [1011 header] + DATA_W data bits + GAP_CYCLES forced zeros.
// Build option: define SEQ_FRAME_TX_SYNC_EN to emit the 1011 header; without
// it the FSM goes IDLE -> DATA directly and the header is never sent.
// Ports:
//   clock         : rising-edge clock
//   reset         : asynchronous, active-high; aborts any frame
//   load_if       : slave side of the word-load handshake
//   sequence_out  : registered serial bit stream
//   frame_active  : high while header or data bits are on sequence_out
//   frame_done    : one-cycle pulse with the last data bit
//   current_state : FSM state (debug)
// -----------------------------------------------------------------------------
module seq_frame_tx
   import seq_frame_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   seq_frame_tx_if.slave        load_if,
   output logic                 sequence_out,
   output logic                 frame_active,
   output logic                 frame_done,
   output logic [1:0]           current_state
);

   localparam int CNT_W = $clog2(max3(DATA_W, GAP_CYCLES, SYNC_W)) + 1;

   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
`ifdef SEQ_FRAME_TX_SYNC_EN
   localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(SYNC_W);
`endif

   // a 1-bit payload makes its only data bit the last one
   localparam logic ONE_BIT_DATA = (DATA_W == 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_seq;
   logic              r_active;
   logic              r_done;

   logic              w_load;
   logic              w_shift;
   logic              w_msb;
   logic [DATA_W-1:0] w_load_word;

   assign load_if.load_ready = (r_state == ST_IDLE);
   assign w_load             = load_if.load_valid && (r_state == ST_IDLE);

   // The serial flop always takes the shifter MSB and the shifter then moves
   // on, so a shift accompanies every data bit launched except the last one.
   assign w_shift = ((r_state == ST_SYNC) && (r_cnt == CNT_ONE)) ||
                    ((r_state == ST_DATA) && (r_cnt != CNT_ONE));

`ifdef SEQ_FRAME_TX_SYNC_EN
   assign w_load_word = load_if.load_data;

   // r_cnt counts 4..1 through the header; the bit launched next is
   // SYNC_PATTERN[r_cnt-2], taken modulo 4 from the low counter bits.
   logic [1:0] w_hdr_idx;
   assign w_hdr_idx = r_cnt[1:0] - 2'd2;
`else
   // With no header the MSB leaves on the handshake edge itself, so the
   // register holds only the bits still to be sent.
   assign w_load_word = load_if.load_data << 1;
`endif

   seq_tx_shifter #(
      .DATA_W (DATA_W)
   ) u_shifter (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_load_word),
      .o_msb   (w_msb)
   );

   // frame FSM: state, bit counter and all registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_seq    <= 1'b0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
`ifdef SEQ_FRAME_TX_SYNC_EN
                  r_state  <= ST_SYNC;
                  r_cnt    <= CNT_SYNC;
                  r_seq    <= SYNC_PATTERN[SYNC_W-1];
                  r_active <= 1'b1;
                  r_done   <= 1'b0;
`else
                  r_state  <= ST_DATA;
                  r_cnt    <= CNT_DATA;
                  r_seq    <= load_if.load_data[DATA_W-1];
                  r_active <= 1'b1;
                  r_done   <= ONE_BIT_DATA;
`endif
               end else begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_seq    <= 1'b0;
                  r_active <= 1'b0;
                  r_done   <= 1'b0;
               end
            end
`ifdef SEQ_FRAME_TX_SYNC_EN
            ST_SYNC: begin
               if (r_cnt == CNT_ONE) begin
                  r_state <= ST_DATA;
                  r_cnt   <= CNT_DATA;
                  r_seq   <= w_msb;
                  r_done  <= ONE_BIT_DATA;
               end else begin
                  r_state <= ST_SYNC;
                  r_cnt   <= r_cnt - CNT_ONE;
                  r_seq   <= SYNC_PATTERN[w_hdr_idx];
                  r_done  <= 1'b0;
               end
               r_active <= 1'b1;
            end
`endif
            ST_DATA: begin
               if (r_cnt == CNT_ONE) begin
                  r_state  <= ST_GAP;
                  r_cnt    <= CNT_GAP;
                  r_seq    <= 1'b0;
                  r_active <= 1'b0;
                  r_done   <= 1'b0;
               end else begin
                  r_state  <= ST_DATA;
                  r_cnt    <= r_cnt - CNT_ONE;
                  r_seq    <= w_msb;
                  r_active <= 1'b1;
                  r_done   <= (r_cnt == CNT_TWO);
               end
            end
            ST_GAP: begin
               if (r_cnt == CNT_ONE) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_state <= ST_GAP;
                  r_cnt   <= r_cnt - CNT_ONE;
               end
               r_seq    <= 1'b0;
               r_active <= 1'b0;
               r_done   <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_cnt    <= '0;
               r_seq    <= 1'b0;
               r_active <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

   assign sequence_out  = r_seq;
   assign frame_active  = r_active;
   assign frame_done    = r_done;
   assign current_state = r_state;

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter: the source end of the team's 1011 sync-detect link. Accepts a parallel data word over a valid/ready handshake and emits it on a single serial line, one bit per clock, MSB first. The frame is:

- an optional 4-bit `1011` sync header,
- then the data bits,
- then a run of forced-zero gap bits.

The block drives the `sequence_in` of a downstream Moore 1011 detector, and is used as its bench stimulus source.

## Interface
- `DATA_W`, default 8 — payload bits per frame; legal range 1..32.
- `GAP_CYCLES`, default 2 — zero bits after each frame; legal range 2..15. Two zeros return any downstream 1011 detector to its idle state.
- `clock`  in  1  — rising-edge clock.
- `reset`  in  1  — reset, asynchronous, active-high; clock is `clock`.
- `load_valid`  in  1  — `load_data` is valid.
- `load_ready`  out  1  — block can accept a word.
- `load_data`  in  `DATA_W`  — payload, captured on handshake only.
- `sequence_out`  out  1  — registered serial bit stream.
- `frame_active`  out  1  — high while header or data bits are on `sequence_out`.
- `frame_done`  out  1  — one-cycle pulse coincident with the last data bit.
- `current_state`  out  2  — FSM state, for debug and bench.

## Operation

**States:**
- `IDLE` = 2'b00
- `SYNC` = 2'b01
- `DATA` = 2'b11
- `GAP` = 2'b10

**Handshake:**
- `load_ready` = (`current_state` == `IDLE`), combinational from the state register.
- A handshake occurs on a rising edge where `load_valid` && `load_ready`. At that edge, `load_data` is copied into the shift register.
- `load_valid` outside `IDLE` is ignored. The source must hold `load_data` until ready.

**Transitions:**
- `IDLE` → `SYNC` on handshake.
- `SYNC` → `DATA` after 4 header bits.
- `DATA` → `GAP` after `DATA_W` bits.
- `GAP` → `IDLE` after `GAP_CYCLES` bits.

**Bit counter:**
- Single down-counter, width `$clog2(max(DATA_W,GAP_CYCLES,4))+1`.
- Reloaded on every state entry.
- Terminal count is 1; no wrap-around.

**Serial output:**
- `sequence_out` in `SYNC`: header bits 1,0,1,1 in order.
- `sequence_out` in `DATA`: shift-register MSB; the register shifts left, zero-filled.
- `sequence_out` in `IDLE` and `GAP`: 0.

**Flags:**
- `frame_active` = state is `SYNC` or `DATA`.
- `frame_done` = 1 only in the final `DATA` cycle.

**Reset:**
- Reset at any time aborts the frame. The block returns to `IDLE`.
- No `frame_done` is produced for the aborted frame.

## Timing

**Reset values:**
- `sequence_out` = 0
- `frame_active` = 0
- `frame_done` = 0
- `current_state` = `IDLE`
- `load_ready` = 1
- shift register and counter cleared

**Latency and frame timing (handshake at edge k):**
- First header bit is visible on `sequence_out` after edge k.
- Data MSB appears after edge k+4.
- Last data bit and `frame_done` appear after edge k+3+`DATA_W`.
- `load_ready` returns after edge k+4+`DATA_W`+`GAP_CYCLES`.

**Occupancy:**
- Each frame occupies 4 + `DATA_W` + `GAP_CYCLES` serial cycles, plus 1 `IDLE` handshake cycle.
- Default period is 15 cycles.

**Combinational paths:** no path from input to output except `load_ready`, which depends on state only.

## Configuration
- Macro: `SEQ_FRAME_TX_SYNC_EN`.
- **Defined:** the `SYNC` header is emitted as described above.
- **Undefined:**
  - `SYNC` is never entered; `IDLE` → `DATA` directly on handshake.
  - Data MSB appears after edge k; all later timings shift by −4 cycles.
  - The state encoding is unchanged.

## Structure
- Package `seq_frame_pkg` holds:
  - the state typedef (2-bit enum with the encodings above),
  - `SYNC_PATTERN` = 4'b1011,
  - `SYNC_W` = 4.
- Sub-module `seq_tx_shifter`: parallel-load, shift-left, zero-fill register of width `DATA_W`. Ports: load, shift, data in, MSB out.
- The FSM, counter and flags stay in the top module.

## Test plan
- **Single frame:** reset, then `load_data`=8'hA5 with `load_valid` held. Required stream on `sequence_out` from the cycle after the handshake: 1011 10100101 00. `frame_done` is high exactly on the final 1. A downstream detector fires once, after the header.
- **Back-to-back words:** 8'hFF then 8'h00, `load_valid` held continuously. Handshakes are exactly 15 cycles apart. `load_ready` is low for 14 cycles between them.
- **Busy/stable data:** toggle `load_data` while the block is busy. The transmitted bits match only the value captured at the handshake.
- **Mid-frame reset:** assert `reset` during the third data bit.
  - Immediately: `sequence_out`=0, `current_state`=`IDLE`, `load_ready`=1.
  - No `frame_done`.
  - The next frame is clean.
- **Without `SEQ_FRAME_TX_SYNC_EN`:** `load_data`=8'h0B. Stream is 00001011 00, with no header. The detector fires once, on the trailing data bits.
- **Parameter corner:** `DATA_W`=1, `GAP_CYCLES`=15, `load_data`=1'b1. Stream is 1011 1 followed by fifteen 0s. `frame_done` is high on the single data bit.
